// File: rtl/matrix_stream_generator.sv
// matrix_stream_generator: AXI4-Stream source of row-major ROWS x COLS matrix batches
//   clk, reset        : clock, synchronous active-high reset
//   start             : pulse that begins a batch when idle
//   mode, const_value : pattern select and constant value, captured on an accepted start
//   repeat_en         : restart the batch automatically at batch end
//   input_r_*_0       : AXIS master (TVALID/TLAST/TDATA out, TREADY in)
//   busy, done        : batch in progress; one-cycle pulse after a non-repeating batch ends
module matrix_stream_generator #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ROWS         = 4,
    parameter int          COLS         = 4,
    parameter int          NUM_MATRICES = 2,
    parameter int          GAP_CYCLES   = 0,
    parameter logic [31:0] SEED         = 32'h00000001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  repeat_en,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic                  input_r_TVALID_0,
    output logic                  input_r_TLAST_0,
    output logic [DATA_WIDTH-1:0] input_r_TDATA_0,
    input  logic                  input_r_TREADY_0,
    output logic                  busy,
    output logic                  done
);
    localparam int          RW       = $clog2(ROWS + 1);
    localparam int          CW       = $clog2(COLS + 1);
    localparam int          MW       = $clog2(NUM_MATRICES + 1);
    localparam int          GW       = $clog2(GAP_CYCLES + 2);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] MASK     = 32'h80200003;
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [MW-1:0]         mat_q, mat_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, const_q, const_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [1:0]            mode_q, mode_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] lfsr_data, pattern;
    logic                  valid, last_col, last_row, last_mat, accept;

    if (DATA_WIDTH <= 32) begin : g_narrow
        assign lfsr_data = lfsr_q[DATA_WIDTH-1:0];
    end else begin : g_wide
        assign lfsr_data = {{(DATA_WIDTH-32){1'b0}}, lfsr_q};
    end

    assign valid    = state_q == SEND;
    assign last_col = col_q == CW'(COLS - 1);
    assign last_row = row_q == RW'(ROWS - 1);
    assign last_mat = mat_q == MW'(NUM_MATRICES - 1);
    assign accept   = valid && input_r_TREADY_0;
    assign pattern  = mode_q == 2'd0 ? cnt_q :
                      mode_q == 2'd1 ? lfsr_data :
                      mode_q == 2'd2 ? DATA_WIDTH'(32'(row_q) == 32'(col_q)) : const_q;

    // Outputs come only from registered state, so they hold steady under backpressure.
    assign input_r_TVALID_0 = valid;
    assign input_r_TLAST_0  = valid && last_row && last_col;
    assign input_r_TDATA_0  = valid ? pattern : '0;
    assign busy             = state_q != IDLE;
    assign done             = done_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        mat_d   = mat_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        const_d = const_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                mode_d  = mode;
                const_d = const_value;
                cnt_d   = '0;
                lfsr_d  = SEED_EFF;
                row_d   = '0;
                col_d   = '0;
                mat_d   = '0;
            end
            SEND: if (accept) begin
                cnt_d  = cnt_q + 1'b1;
                lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 32'h0);
                col_d  = last_col ? '0 : col_q + 1'b1;
                row_d  = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
                if (last_col && last_row) begin
                    mat_d = last_mat ? '0 : mat_q + 1'b1;
                    if (last_mat && !repeat_en) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                state_d = gap_q == '0 ? SEND : GAP;
                gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mat_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
            mode_q  <= '0;
            const_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mat_q   <= mat_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            const_q <= const_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_matrix_stream_generator.sv
// tb_matrix_stream_generator: directed + randomized checks of the matrix stream source
module tb_matrix_stream_generator;
    localparam int R = 2, C = 3, N = 2, G = 2, DW = 32;
    localparam int BEATS = R * C * N;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, repeat_en = 1'b0, tready = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] const_value = '0, tdata;
    logic          tvalid, tlast, busy, done;

    int errors = 0, checks = 0;

    logic [31:0] m_cnt, m_lfsr, m_const;
    int          m_mode;
    bit          pend;
    int          gapcnt;

    matrix_stream_generator #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .NUM_MATRICES(N),
        .GAP_CYCLES(G), .SEED(32'h00000001)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .repeat_en(repeat_en),
        .const_value(const_value),
        .input_r_TVALID_0(tvalid), .input_r_TLAST_0(tlast), .input_r_TDATA_0(tdata),
        .input_r_TREADY_0(tready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected value for element k of the batch, from the pattern rules.
    function automatic logic [31:0] exp_data(input int k);
        int e = k % (R * C);
        case (m_mode)
            0: return m_cnt;
            1: return m_lfsr;
            2: return {31'b0, (e / C) == (e % C)};
            default: return m_const;
        endcase
    endfunction

    task automatic do_start(input int m, input logic [31:0] cv);
        mode = 2'(m);
        const_value = cv;
        start = 1'b1;
        step();
        start = 1'b0;
        m_mode = m; m_const = cv; m_cnt = 0; m_lfsr = 32'h1; pend = 0;
        chk("start_valid", {63'b0, tvalid}, 64'd1);
        chk("start_busy", {63'b0, busy}, 64'd1);
    endtask

    // Consume n beats; style 0 ready always, 1 alternating, 2 random.
    task automatic drain(input int n, input int style);
        int got = 0, guard = 0, k0;
        bit ph = 1'b1;
        logic r;
        k0 = (m_mode == 2) ? 0 : 0;
        while (got < n && guard < 1000) begin
            r = style == 0 ? 1'b1 : style == 1 ? ph : 1'($urandom_range(0, 1));
            ph = !ph;
            tready = r;
            if (tvalid) begin
                if (pend) chk("gap_len", 64'(gapcnt), 64'(G));
                pend = 0;
                chk("tdata", 64'(tdata), 64'(exp_data(int'(m_cnt) + k0)));
                chk("tlast", {63'b0, tlast}, {63'b0, (int'(m_cnt) % (R * C)) == R * C - 1});
                if (r) begin
                    if (tlast) begin pend = 1; gapcnt = 0; end
                    m_cnt++;
                    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
                    got++;
                end
            end else if (pend) gapcnt++;
            else chk("valid_hold", {63'b0, tvalid}, 64'd1);
            step();
            guard++;
        end
        chk("beats", 64'(got), 64'(n));
    endtask

    task automatic expect_done();
        chk("done_pulse", {63'b0, done}, 64'd1);
        chk("busy_fall", {63'b0, busy}, 64'd0);
        chk("valid_low", {63'b0, tvalid}, 64'd0);
        step();
        chk("done_clear", {63'b0, done}, 64'd0);
    endtask

    initial begin
        step(); step();
        chk("rst_valid", {63'b0, tvalid}, 64'd0);
        chk("rst_last", {63'b0, tlast}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_data", 64'(tdata), 64'd0);
        reset = 1'b0;
        step();

        // increment, always ready
        do_start(0, 32'h0);
        drain(BEATS, 0);
        expect_done();

        // increment, alternating ready; mode/const changes mid-batch ignored
        do_start(0, 32'h0);
        mode = 2'd3; const_value = 32'hDEAD;
        drain(BEATS, 1);
        expect_done();

        // identity, random ready
        do_start(2, 32'h0);
        drain(BEATS, 2);
        expect_done();

        // LFSR: explicit first values, then model-checked with random ready
        do_start(1, 32'h0);
        tready = 1'b1;
        chk("lfsr0", 64'(tdata), 64'h00000001);
        step();
        chk("lfsr1", 64'(tdata), 64'h80200003);
        step();
        chk("lfsr2", 64'(tdata), 64'hC0300002);
        m_cnt = 2; m_lfsr = 32'hC0300002;
        drain(BEATS - 2, 2);
        expect_done();

        // constant, random value, random ready
        do_start(3, $urandom);
        drain(BEATS, 2);
        expect_done();

        // reset mid-batch after the 3rd accepted beat
        do_start(0, 32'h0);
        drain(3, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", {63'b0, tvalid}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        step();
        chk("abort_done2", {63'b0, done}, 64'd0);

        // simultaneous start and reset: reset wins
        start = 1'b1; reset = 1'b1;
        step();
        start = 1'b0; reset = 1'b0;
        chk("sr_busy", {63'b0, busy}, 64'd0);
        chk("sr_valid", {63'b0, tvalid}, 64'd0);

        do_start(0, 32'h0);
        drain(BEATS, 0);
        expect_done();

        // repeat: start mid-batch ignored, counter continues, done only at final batch
        repeat_en = 1'b1;
        do_start(0, 32'h0);
        drain(5, 0);
        start = 1'b1;
        drain(1, 0);
        start = 1'b0;
        drain(BEATS - 6, 2);
        chk("rep_nodone", {63'b0, done}, 64'd0);
        chk("rep_busy", {63'b0, busy}, 64'd1);
        repeat_en = 1'b0;
        drain(BEATS, 2);
        expect_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
